// File: rtl/keypad_scanner_if.sv
// Keypad scanner bundle: matrix lines toward the keypad plus the key report
// toward the game/maze control logic.
interface keypad_scanner_if;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // Scanner side: reads the columns, drives the rows and the key report.
  modport master (
    input  col_in,
    output row_out,
    output key_code,
    output key_valid,
    output key_held
  );

  // Keypad/consumer side: drives the columns, observes everything else.
  modport slave (
    output col_in,
    input  row_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner.
// Each row is driven low in turn for SCAN_DIV cycles and the synchronized column
// lines are sampled on the last cycle of each row. The four row samples of one
// frame are folded into NONE / KEY(code) / MULTI. A result has to repeat for
// DEBOUNCE_SCANS whole frames before a press or a release is accepted, and a
// press is reported once with a single-cycle key_valid pulse.
module keypad_scanner #(
  parameter int SCAN_DIV       = 64,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic              clk,
  input logic              rst,
  keypad_scanner_if.master kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } frame_res_t;

  typedef enum logic {
    ARMED   = 1'b0,
    PRESSED = 1'b1
  } state_t;

  logic [3:0]    col_meta;
  logic [3:0]    col_sync;
  logic [DW-1:0] div;
  logic [1:0]    row_idx;
  logic          sample_tick;
  logic          frame_end;

  logic [3:0]    row_low;
  logic [2:0]    row_cnt;
  logic [1:0]    low_col;
  logic [2:0]    low_sum;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;
  logic [1:0]    frame_cnt;
  logic [3:0]    frame_code;
  frame_res_t    frame_res;

  frame_res_t    cand_kind;
  frame_res_t    cand_kind_nxt;
  logic [3:0]    cand_code;
  logic [3:0]    cand_code_nxt;
  logic [SW-1:0] stable;
  logic [SW-1:0] stable_nxt;

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic          held;

  logic          key_valid_r;
  logic [3:0]    key_code_r;

  // Two-flop synchronizer for the asynchronous, pulled-up column lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta <= 4'b1111;
      col_sync <= 4'b1111;
    end else begin
      col_meta <= kp.col_in;
      col_sync <= col_meta;
    end
  end

  // Row timing: div counts the cycles of the current row; row changes as div wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div     <= '0;
      row_idx <= 2'd0;
    end else if (div == DIV_LAST) begin
      div     <= '0;
      row_idx <= row_idx + 2'd1;
    end else begin
      div     <= div + DW'(1);
    end
  end

  assign sample_tick = (div == DIV_LAST);
  assign frame_end   = sample_tick && (row_idx == 2'd3);

  // One-cold row drive decoded straight from the row index, so reset shows at once.
  always_comb begin
    kp.row_out = ~(4'b0001 << row_idx);
  end

  // Fold the current row sample into the running frame count and single-key code.
  always_comb begin
    row_low = ~col_sync;
    row_cnt = {2'b00, row_low[0]} + {2'b00, row_low[1]} +
              {2'b00, row_low[2]} + {2'b00, row_low[3]};
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (row_low[i]) low_col = 2'(i);
    end
    low_sum    = {1'b0, acc_cnt} + row_cnt;
    frame_cnt  = (low_sum >= 3'd2) ? 2'd2 : low_sum[1:0];
    frame_code = ((acc_cnt == 2'd0) && (row_cnt == 3'd1)) ? {row_idx, low_col} : acc_code;
    case (frame_cnt)
      2'd0:    frame_res = RES_NONE;
      2'd1:    frame_res = RES_KEY;
      default: frame_res = RES_MULTI;
    endcase
  end

  // Frame accumulator: updated on every row sample, cleared once the frame is folded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (frame_end) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (sample_tick) begin
      acc_cnt  <= frame_cnt;
      acc_code <= frame_code;
    end
  end

  // Debounce: a repeating frame result builds confidence, any change restarts at one.
  always_comb begin
    cand_kind_nxt = cand_kind;
    cand_code_nxt = cand_code;
    stable_nxt    = stable;
    if (frame_end) begin
      if ((frame_res == cand_kind) &&
          ((frame_res != RES_KEY) || (frame_code == cand_code))) begin
        if (stable != STABLE_MAX) stable_nxt = stable + SW'(1);
      end else begin
        cand_kind_nxt = frame_res;
        cand_code_nxt = frame_code;
        stable_nxt    = SW'(1);
      end
    end
  end

  // Debounce registers holding the candidate result and its frame count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_kind <= RES_NONE;
      cand_code <= 4'd0;
      stable    <= '0;
    end else begin
      cand_kind <= cand_kind_nxt;
      cand_code <= cand_code_nxt;
      stable    <= stable_nxt;
    end
  end

  // Press/release FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARMED;
    else      state <= state_nxt;
  end

  // Next state uses the freshly updated candidate so acceptance lands on the frame end.
  always_comb begin
    state_nxt = state;
    case (state)
      ARMED: begin
        if (frame_end && (cand_kind_nxt == RES_KEY) && (stable_nxt == STABLE_MAX))
          state_nxt = PRESSED;
      end
      PRESSED: begin
        if (frame_end && (cand_kind_nxt == RES_NONE) && (stable_nxt == STABLE_MAX))
          state_nxt = ARMED;
      end
      default: state_nxt = ARMED;
    endcase
  end

  // FSM outputs: a press is accepted on the ARMED->PRESSED step; held mirrors PRESSED.
  always_comb begin
    accept = (state == ARMED) && (state_nxt == PRESSED);
    held   = (state == PRESSED);
  end

  // Key report registers: one-cycle valid pulse and a code that persists past release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid_r <= 1'b0;
      key_code_r  <= 4'd0;
    end else begin
      key_valid_r <= accept;
      if (accept) key_code_r <= cand_code_nxt;
    end
  end

  assign kp.key_valid = key_valid_r;
  assign kp.key_code  = key_code_r;
  assign kp.key_held  = held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model driven by a set of pressed
// keys, a frame-level reference model of debounce and reporting, and a
// per-cycle compare of every output against that model.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] pressed = '0;

  int vectors    = 0;
  int miscompares = 0;

  int n = 0;
  int cand_kind = 0;
  int cand_code = 0;
  int stable = 0;
  bit exp_held = 1'b0;
  bit exp_valid = 1'b0;
  int exp_code = 0;
  logic [15:0] frame_mask = '0;
  int pulse_count = 0;
  int last_pulse_n = -1;
  bit prev_valid = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner_if kp_if ();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_if)
  );

  // Keypad matrix: a column reads low when a pressed key sits on the driven row.
  always_comb begin
    kp_if.col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp_if.row_out[r]) kp_if.col_in[c] = 1'b0;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Hold a key set for a number of whole frames, starting just after a frame boundary.
  task automatic applyStimulus(input logic [15:0] mask, input int frames);
    pressed = mask;
    repeat (frames * FRAME) @(posedge clk);
    #1;
  endtask

  // Reference model stepped once per frame from the set of keys held during it.
  task automatic modelFrameEnd(input logic [15:0] mask);
    int kind;
    int code;
    kind = ($countones(mask) == 0) ? 0 : (($countones(mask) == 1) ? 1 : 2);
    code = 0;
    for (int i = 0; i < 16; i++) if (mask[i]) code = i;
    if (kind == cand_kind && (kind != 1 || code == cand_code)) begin
      if (stable < DB) stable++;
    end else begin
      cand_kind = kind;
      cand_code = code;
      stable    = 1;
    end
    if (!exp_held) begin
      if (cand_kind == 1 && stable == DB) begin
        exp_valid = 1'b1;
        exp_held  = 1'b1;
        exp_code  = cand_code;
      end
    end else if (cand_kind == 0 && stable == DB) begin
      exp_held = 1'b0;
    end
  endtask

  // Compare process: checks all outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      n = 0; cand_kind = 0; cand_code = 0; stable = 0;
      exp_held = 1'b0; exp_valid = 1'b0; exp_code = 0; prev_valid = 1'b0;
      checkOutput("reset_row_out", int'(kp_if.row_out), 4'b1110);
      checkOutput("reset_key_valid", int'(kp_if.key_valid), 0);
      checkOutput("reset_key_held", int'(kp_if.key_held), 0);
      checkOutput("reset_key_code", int'(kp_if.key_code), 0);
    end else begin
      n++;
      exp_valid = 1'b0;
      if (n % FRAME == FRAME / 2) frame_mask = pressed;
      if (n % FRAME == 0) modelFrameEnd(frame_mask);
      checkOutput("row_out", int'(kp_if.row_out), int'(4'hF & ~(4'b0001 << ((n / SCAN_DIV) % 4))));
      checkOutput("key_valid", int'(kp_if.key_valid), int'(exp_valid));
      checkOutput("key_held", int'(kp_if.key_held), int'(exp_held));
      checkOutput("key_code", int'(kp_if.key_code), exp_code);
      if (kp_if.key_valid) begin
        pulse_count++;
        last_pulse_n = n;
        checkOutput("valid_back_to_back", int'(prev_valid), 0);
      end
      prev_valid = kp_if.key_valid;
    end
  end

  initial begin
    int pc0;
    logic [15:0] mask;
    int kind;
    int a;
    int b;

    $display("[TB] keypad_scanner bench start");
    rst = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    // Key 9 (row 2, col 1) held five frames, then released two frames.
    pc0 = pulse_count;
    applyStimulus(16'h0001 << 9, 5);
    checkOutput("press9_pulses", pulse_count - pc0, 1);
    checkOutput("press9_latency", last_pulse_n, 2 * FRAME);
    checkOutput("press9_code", int'(kp_if.key_code), 9);
    checkOutput("press9_held", int'(kp_if.key_held), 1);
    applyStimulus('0, 2);
    checkOutput("release9_held", int'(kp_if.key_held), 0);
    checkOutput("release9_code_kept", int'(kp_if.key_code), 9);

    // Single-frame bounce on key 5.
    pc0 = pulse_count;
    applyStimulus(16'h0001 << 5, 1);
    applyStimulus('0, 2);
    checkOutput("bounce5_pulses", pulse_count - pc0, 0);
    checkOutput("bounce5_held", int'(kp_if.key_held), 0);

    // Keys 0 and 15 together, then 15 alone.
    pc0 = pulse_count;
    applyStimulus(16'h8001, 4);
    checkOutput("multi_pulses", pulse_count - pc0, 0);
    applyStimulus(16'h8000, 3);
    checkOutput("key15_pulses", pulse_count - pc0, 1);
    checkOutput("key15_code", int'(kp_if.key_code), 15);
    applyStimulus('0, 2);

    // Slide from key 3 to key 7 without releasing.
    pc0 = pulse_count;
    applyStimulus(16'h0008, 3);
    checkOutput("slide3_code", int'(kp_if.key_code), 3);
    applyStimulus(16'h0080, 3);
    checkOutput("slide7_pulses", pulse_count - pc0, 1);
    checkOutput("slide7_code_still3", int'(kp_if.key_code), 3);
    applyStimulus('0, 2);
    checkOutput("slide_release_held", int'(kp_if.key_held), 0);
    applyStimulus(16'h0080, 3);
    checkOutput("press7_pulses", pulse_count - pc0, 2);
    checkOutput("press7_code", int'(kp_if.key_code), 7);
    applyStimulus('0, 2);

    // Random key sets: none, single, or two keys, each held 1..4 frames.
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      mask = '0;
      if (kind >= 1) mask[a] = 1'b1;
      if (kind == 2) mask[b] = 1'b1;
      applyStimulus(mask, $urandom_range(1, 4));
    end
    applyStimulus('0, 3);

    // Reset while key 10 is held down; it must be reported again afterwards.
    applyStimulus(16'h0400, 3);
    checkOutput("pre_reset_held", int'(kp_if.key_held), 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkOutput("async_reset_row_out", int'(kp_if.row_out), 4'b1110);
    checkOutput("async_reset_valid", int'(kp_if.key_valid), 0);
    checkOutput("async_reset_held", int'(kp_if.key_held), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    pc0 = pulse_count;
    applyStimulus(16'h0400, 3);
    checkOutput("rereport_pulses", pulse_count - pc0, 1);
    checkOutput("rereport_latency", last_pulse_n, 2 * FRAME);
    checkOutput("rereport_code", int'(kp_if.key_code), 10);
    applyStimulus('0, 2);
    checkOutput("final_held", int'(kp_if.key_held), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
